// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ARM data-processing opcodes, the
// control FSM encoding and the bit positions inside the NZCV flag register.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_EOR = 4'd1,
    OP_SUB = 4'd2,
    OP_RSB = 4'd3,
    OP_ADD = 4'd4,
    OP_ADC = 4'd5,
    OP_SBC = 4'd6,
    OP_RSC = 4'd7,
    OP_TST = 4'd8,
    OP_TEQ = 4'd9,
    OP_CMP = 4'd10,
    OP_CMN = 4'd11,
    OP_ORR = 4'd12,
    OP_MOV = 4'd13,
    OP_BIC = 4'd14,
    OP_MVN = 4'd15
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULB = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// done pulses during the final iteration; product is valid in that cycle.
module mul_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [4:0]       cnt;
  logic             busy;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    done    = busy && (cnt == 5'(MUL_CYCLES - 1));
    product = acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_flags.sv
// Execute stage: ARM data-processing ALU, RRX and iterative MUL, with the
// architectural NZCV register and a registered valid/ready result port.
module alu_flags
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             shc,
  input  logic [3:0]       aluOp,
  input  logic             setFlags,
  input  logic             rrx,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wrEn,
  output logic [3:0]       flags,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; once valid is raised its payload is held until that edge.
  state_t           state, state_nxt;
  aluop_t           op;
  logic             accept;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;
  logic             mul_s;
  logic [WIDTH-1:0] x, y, res;
  logic             ci, arith, nf_c, nf_v, cmp_op;
  logic [WIDTH:0]   sum;
  logic [3:0]       new_flags;

  mul_iter #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && mul),
    .a       (src1),
    .b       (src2),
    .done    (mul_done),
    .product (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = mul ? MULB : DONE;
      MULB:    if (mul_done) state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_nxt = mul ? MULB : DONE;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    dbg_state = state;
  end

  // Subtracts are formed as x + ~y + ci, so the carry-out is NOT borrow.
  always_comb begin
    op    = aluop_t'(aluOp);
    x     = src1;
    y     = src2;
    ci    = 1'b0;
    arith = 1'b0;
    res   = '0;
    nf_c  = shc;
    nf_v  = flags[FLAG_V];
    case (op)
      OP_AND, OP_TST: res = src1 & src2;
      OP_EOR, OP_TEQ: res = src1 ^ src2;
      OP_ORR:         res = src1 | src2;
      OP_MOV:         res = src2;
      OP_BIC:         res = src1 & ~src2;
      OP_MVN:         res = ~src2;
      OP_SUB, OP_CMP: begin y = ~src2; ci = 1'b1;           arith = 1'b1; end
      OP_RSB:         begin x = src2; y = ~src1; ci = 1'b1; arith = 1'b1; end
      OP_ADD, OP_CMN: begin                                 arith = 1'b1; end
      OP_ADC:         begin ci = flags[FLAG_C];             arith = 1'b1; end
      OP_SBC:         begin y = ~src2; ci = flags[FLAG_C];  arith = 1'b1; end
      OP_RSC:         begin x = src2; y = ~src1; ci = flags[FLAG_C]; arith = 1'b1; end
      default:        res = '0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    if (arith) begin
      res  = sum[WIDTH-1:0];
      nf_c = sum[WIDTH];
      nf_v = (x[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
    end
    cmp_op = 1'b0;
    if (rrx) begin
      res  = {flags[FLAG_C], src2[WIDTH-1:1]};
      nf_c = src2[0];
      nf_v = flags[FLAG_V];
    end else begin
      cmp_op = (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    end
    new_flags = (setFlags || cmp_op) ?
                {res[WIDTH-1], (res == '0), nf_c, nf_v} : flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      wrEn   <= 1'b0;
      flags  <= 4'b0000;
      mul_s  <= 1'b0;
    end else if (accept && !mul) begin
      result <= res;
      wrEn   <= !cmp_op;
      flags  <= new_flags;
    end else if (accept && mul) begin
      mul_s  <= setFlags;
    end else if ((state == MULB) && mul_done) begin
      result <= mul_p;
      wrEn   <= 1'b1;
      if (mul_s) begin
        flags[FLAG_N] <= mul_p[WIDTH-1];
        flags[FLAG_Z] <= (mul_p == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_flags.sv
// Directed bench for alu_flags: a driver pushes hand-computed expectations
// into a queue and a monitor pops and compares them on every handshake.
module tb_alu_flags;
  import alu_pkg::*;

  localparam int EW = 37;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        shc = 1'b0;
  logic [3:0]  aluOp = '0;
  logic        setFlags = 1'b0;
  logic        rrx = 1'b0;
  logic        mul = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        wrEn;
  logic [3:0]  flags;
  logic [1:0]  dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] act_v;
  int n_tests = 0;
  int n_fail  = 0;

  alu_flags dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .shc(shc), .aluOp(aluOp), .setFlags(setFlags),
    .rrx(rrx), .mul(mul), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .wrEn(wrEn), .flags(flags), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake is scored against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_tests++;
      act_v = {result, wrEn, flags};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got res=0x%08h wr=%0b nzcv=%04b, none expected",
                 result, wrEn, flags);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL output: got res=0x%08h wr=%0b nzcv=%04b expected res=0x%08h wr=%0b nzcv=%04b",
                   result, wrEn, flags, exp_v[36:5], exp_v[4], exp_v[3:0]);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic c_sh, input logic sf, input logic r, input logic m,
                      input logic [31:0] e_res, input logic e_wr, input logic [3:0] e_fl,
                      input logic push_en);
    int wait_n;
    in_valid = 1'b1; aluOp = op; src1 = a; src2 = b; shc = c_sh;
    setFlags = sf; rrx = r; mul = m;
    wait_n = 0;
    @(negedge clk);
    while (!in_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", wait_n);
    end else if (push_en) begin
      exp_q.push_back({e_res, e_wr, e_fl});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rrx = 1'b0; mul = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cyc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_wren",      64'(wrEn),      64'd0);
    check("rst_flags",     64'(flags),     64'd0);
    check("rst_state",     64'(dbg_state), 64'(IDLE));
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0110, 1'b1);
    check("adds_latency", 64'(out_valid), 64'd1);

    send(OP_CMP, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 4'b1000, 1'b1);
    send(OP_ADC, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1, 4'b1000, 1'b1);
    drain();

    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0110, 1'b1);
    send(OP_MOV, 32'h0, 32'h3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0001, 1'b1, 4'b1010, 1'b1);
    drain();

    send(OP_ADD, 32'h0001_0000, 32'h0001_0001, 1'b0, 1'b1, 1'b0, 1'b1,
         32'h0001_0000, 1'b1, 4'b0010, 1'b1);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      if (cyc == 3) begin
        in_valid = 1'b1; aluOp = OP_MOV; src2 = 32'h55; setFlags = 1'b1;
      end
      if (cyc == 5) check("mulb_in_ready", 64'(in_ready), 64'd0);
      if (cyc == 8) in_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("mul_latency", 64'(cyc), 64'd33);
    drain();

    out_ready = 1'b0;
    send(OP_ORR, 32'hF0, 32'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFF, 1'b1, 4'b0010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result",    64'(result),    64'hFF);
      check("bp_flags",     64'(flags),     64'b0010);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_SUB, 32'd3, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0110, 1'b1);
    check("subs_no_bubble", 64'(out_valid), 64'd1);
    drain();

    send(OP_ADD, 32'd7, 32'd9, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 4'b0000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_flags",     64'(flags),     64'd0);
    check("abort_state",     64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(OP_ADD, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b1, 4'b0000, 1'b1);
    send(OP_TST, 32'hF0, 32'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0100, 1'b1);
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 4'b1001, 1'b1);
    send(OP_SBC, 32'd5, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 4'b0010, 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
